// File: rtl/fetch_pkg.sv
// Shared types and helpers for the instruction-fetch stage.
//   fetch_state_t  : fetch sequencer states
//   OP_*           : LEGv8 branch opcodes (B, CBZ, B.cond)
//   sext_br_offset : byte offset of a B (imm26) or CBZ/B.cond (imm19) branch
package fetch_pkg;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DRAIN} fetch_state_t;

  localparam logic [5:0] OP_B     = 6'b000101;
  localparam logic [7:0] OP_CBZ   = 8'b10110100;
  localparam logic [7:0] OP_BCOND = 8'b01010100;

  localparam int BR_ADDR_W = 64;

  // Sign-extended immediate, scaled to bytes (word offset << 2).
  function automatic logic [BR_ADDR_W-1:0] sext_br_offset(input logic [31:0] inst,
                                                          input logic        uncond);
    logic [BR_ADDR_W-1:0] off;
    if (uncond) off = {{(BR_ADDR_W-28){inst[25]}}, inst[25:0], 2'b00};
    else        off = {{(BR_ADDR_W-21){inst[23]}}, inst[23:5], 2'b00};
    return off;
  endfunction

endpackage

// File: rtl/fetch_unit_fifo.sv
// Two-entry instruction buffer holding {inst, pc}. Output is taken straight
// from storage flops, so a pushed entry is visible the cycle after the push.
//   clk_i, rst_ni : clock, async active-low reset
//   push_i/pop_i  : enqueue wdata_i / dequeue head at the edge
//   flush_i       : empty the buffer (wins over push/pop)
//   rdata_o       : head entry, count_o : occupancy 0..2
module fetch_fifo #(
  parameter int W = 96
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic         flush_i,
  input  logic [W-1:0] wdata_i,
  output logic [W-1:0] rdata_o,
  output logic [1:0]   count_o
);

  logic [1:0][W-1:0] mem_q;
  logic              wr_q, rd_q;
  logic [1:0]        cnt_q;
  logic              do_push, do_pop;

  assign do_pop  = pop_i && (cnt_q != 2'd0);
  // Push into a full buffer is legal only when the head leaves at the same edge.
  assign do_push = push_i && ((cnt_q != 2'd2) || do_pop);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q <= '0;
      wr_q  <= 1'b0;
      rd_q  <= 1'b0;
      cnt_q <= 2'd0;
    end else if (flush_i) begin
      wr_q  <= 1'b0;
      rd_q  <= 1'b0;
      cnt_q <= 2'd0;
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= wdata_i;
        wr_q        <= ~wr_q;
      end
      if (do_pop) rd_q <= ~rd_q;
      cnt_q <= cnt_q + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

  assign rdata_o = mem_q[rd_q];
  assign count_o = cnt_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, issues word fetches over a valid/ready
// request channel, buffers responses in a 2-entry FIFO and hands {inst, pc}
// to decode. Taken branches redirect the PC and flush the buffer; a response
// already in flight at redirect time is drained and discarded.
//   clk, rst (async, active low)
//   imem_req_valid/ready, imem_addr   : fetch request
//   imem_rsp_valid, imem_rsp_data     : in-order response, one per request
//   inst_valid/ready, inst, inst_pc   : buffered instruction to decode
//   BrTaken, UncondBr, br_inst, br_pc : branch redirect
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int                ADDR_W     = 64,
  parameter int                INST_W     = 32,
  parameter logic [ADDR_W-1:0] RESET_PC   = '0,
  parameter int                FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_rsp_valid,
  input  logic [INST_W-1:0] imem_rsp_data,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [INST_W-1:0] inst,
  output logic [ADDR_W-1:0] inst_pc,
  input  logic              BrTaken,
  input  logic              UncondBr,
  input  logic [INST_W-1:0] br_inst,
  input  logic [ADDR_W-1:0] br_pc
);

  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);

  fetch_state_t      state_q, state_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] req_pc_q, req_pc_d;   // PC of the outstanding request
  logic              outst_q, outst_d;
  logic [ADDR_W-1:0] target;
  logic              credit, accept, push, pop, flush;
  logic [1:0]        fifo_cnt;
  logic [INST_W+ADDR_W-1:0] fifo_rdata;

  assign target    = br_pc + ADDR_W'(sext_br_offset(br_inst, UncondBr));
  assign imem_addr = fetch_pc_q & ALIGN_MASK;

  // Buffered plus in-flight instructions never exceed the buffer size.
  assign credit         = (int'(fifo_cnt) + int'(outst_q)) < FIFO_DEPTH;
  assign imem_req_valid = (state_q == REQ) && credit && !BrTaken;
  assign accept         = imem_req_valid && imem_req_ready;
  assign inst_valid     = (fifo_cnt != 2'd0);
  assign pop            = inst_valid && inst_ready;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    outst_d    = outst_q;
    push       = 1'b0;
    flush      = 1'b0;
    if (BrTaken) begin
      // Redirect wins: a same-cycle response is dropped; one still in flight
      // is drained later. No request can be accepted this cycle.
      flush      = 1'b1;
      fetch_pc_d = target;
      outst_d    = outst_q && !imem_rsp_valid;
      state_d    = outst_d ? DRAIN : REQ;
    end else begin
      unique case (state_q)
        IDLE: state_d = REQ;
        REQ: if (accept) begin
          outst_d    = 1'b1;
          req_pc_d   = imem_addr;
          fetch_pc_d = imem_addr + ADDR_W'(4);
          state_d    = WAIT;
        end
        WAIT: if (imem_rsp_valid) begin
          push    = 1'b1;
          outst_d = 1'b0;
          state_d = REQ;
        end
        DRAIN: if (imem_rsp_valid) begin
          outst_d = 1'b0;
          state_d = REQ;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= '0;
      outst_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
      outst_q    <= outst_d;
    end
  end

  fetch_fifo #(.W(INST_W + ADDR_W)) u_fifo (
    .clk_i   (clk),
    .rst_ni  (rst),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (flush),
    .wdata_i ({imem_rsp_data, req_pc_q}),
    .rdata_o (fifo_rdata),
    .count_o (fifo_cnt)
  );

  assign inst    = fifo_rdata[INST_W+ADDR_W-1:ADDR_W];
  assign inst_pc = fifo_rdata[ADDR_W-1:0];

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios followed by randomized traffic,
// all checked against a transaction-level model (queue of buffered PCs,
// outstanding-request flag, next fetch address).
module tb_fetch_unit;
  import fetch_pkg::*;

  localparam logic [63:0] RPC = 64'h0;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        imem_req_valid, imem_req_ready = 1'b0;
  logic [63:0] imem_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        inst_valid, inst_ready = 1'b0;
  logic [31:0] inst;
  logic [63:0] inst_pc;
  logic        BrTaken = 1'b0, UncondBr = 1'b0;
  logic [31:0] br_inst = '0;
  logic [63:0] br_pc = '0;

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc),
    .BrTaken(BrTaken), .UncondBr(UncondBr), .br_inst(br_inst), .br_pc(br_pc)
  );

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Stimulus knobs applied by step()
  bit          rst_r = 0, rdy_r = 0, ird_r = 0, br_r = 0, unc_r = 0;
  logic [31:0] binst_r = '0;
  logic [63:0] bpc_r = '0;
  int          lat = 1;

  // Memory: one pending response with a latency countdown
  bit          mpend = 0;
  logic [63:0] maddr = '0;
  int          mcnt = 0;

  // Reference model
  logic [63:0] mq[$];
  bit          started = 0, m_out = 0, m_stale = 0;
  logic [63:0] m_opc = '0, m_next = RPC;

  logic [63:0] acc_log[$];
  logic [63:0] pop_log[$];

  function automatic logic [31:0] memf(input logic [63:0] a);
    return (a[31:0] * 32'h9E3779B1) ^ a[63:32] ^ 32'h1234_5678;
  endfunction

  function automatic logic [63:0] br_target(input logic [31:0] bi, input bit unc,
                                            input logic [63:0] pc);
    longint v;
    if (unc) begin
      v = longint'(bi[25:0]);
      if (v >= 64'sd33554432) v -= 64'sd67108864;
    end else begin
      v = longint'(bi[23:5]);
      if (v >= 64'sd262144) v -= 64'sd524288;
    end
    return pc + 64'(v * 4);
  endfunction

  task automatic step();
    bit rsp, acc, acc_dut, pop, exp_rv;
    @(negedge clk);
    rst            = rst_r;
    imem_req_ready = rdy_r;
    inst_ready     = ird_r;
    BrTaken        = br_r;
    UncondBr       = unc_r;
    br_inst        = binst_r;
    br_pc          = bpc_r;
    rsp            = mpend && (mcnt == 0);
    imem_rsp_valid = rsp;
    imem_rsp_data  = rsp ? memf(maddr) : 32'hDEAD_BEEF;
    #1;
    if (!rst_r) begin
      chk("rst_req_valid", 64'(imem_req_valid), 64'(0));
      chk("rst_inst_valid", 64'(inst_valid), 64'(0));
      chk("rst_addr", imem_addr, RPC);
      chk("rst_inst", 64'(inst), 64'(0));
      chk("rst_inst_pc", inst_pc, 64'(0));
      mq.delete();
      started = 0; m_out = 0; m_stale = 0; m_next = RPC;
    end else begin
      exp_rv = started && !br_r && !m_out && (mq.size() < 2);
      chk("req_valid", 64'(imem_req_valid), 64'(exp_rv));
      if (exp_rv) chk("imem_addr", imem_addr, m_next);
      chk("inst_valid", 64'(inst_valid), 64'(mq.size() != 0));
      if (mq.size() != 0) begin
        chk("inst_pc", inst_pc, mq[0]);
        chk("inst", 64'(inst), 64'(memf(mq[0])));
      end
      if (inst_valid && ird_r) pop_log.push_back(inst_pc);
      acc = exp_rv && rdy_r;
      pop = (mq.size() != 0) && ird_r;
      if (br_r) begin
        mq.delete();
        m_next = br_target(binst_r, unc_r, bpc_r);
        if (m_out && rsp) begin m_out = 0; m_stale = 0; end
        else if (m_out) m_stale = 1;
      end else begin
        if (pop) void'(mq.pop_front());
        if (rsp && m_out) begin
          if (!m_stale) mq.push_back(m_opc);
          m_out = 0; m_stale = 0;
        end
        if (acc) begin
          m_out = 1; m_stale = 0; m_opc = m_next; m_next = m_next + 64'd4;
        end
      end
      started = 1;
    end
    // Memory side follows what the DUT actually issued
    acc_dut = imem_req_valid && rdy_r;
    if (rsp) mpend = 0;
    else if (mpend) mcnt--;
    if (acc_dut) begin
      mpend = 1; maddr = imem_addr; mcnt = lat - 1;
      acc_log.push_back(imem_addr);
    end
  endtask

  task automatic wait_acc(input string tag, input int maxc);
    int n0 = acc_log.size();
    int k = 0;
    while (acc_log.size() == n0 && k < maxc) begin step(); k++; end
    chk(tag, 64'(acc_log.size() > n0), 64'(1));
  endtask

  initial begin
    // Reset state
    rst_r = 0; step(); step();

    // 1: streaming, k=1
    acc_log.delete(); pop_log.delete();
    rst_r = 1; rdy_r = 1; ird_r = 1; lat = 1;
    repeat (9) step();
    chk("t1_nacc", 64'(acc_log.size() >= 3), 64'(1));
    chk("t1_nacc_pop", 64'(pop_log.size() >= 3), 64'(1));
    if (acc_log.size() >= 3 && pop_log.size() >= 3) begin
      chk("t1_addr0", acc_log[0], 64'h0);
      chk("t1_addr1", acc_log[1], 64'h4);
      chk("t1_addr2", acc_log[2], 64'h8);
      chk("t1_pc0", pop_log[0], 64'h0);
      chk("t1_pc1", pop_log[1], 64'h4);
      chk("t1_pc2", pop_log[2], 64'h8);
    end

    // 2: decode stalled -> exactly two requests, then one pop frees a slot
    rst_r = 0; step();
    acc_log.delete();
    rst_r = 1; ird_r = 0;
    repeat (10) step();
    chk("t2_two_reqs", 64'(acc_log.size()), 64'(2));
    chk("t2_req_low", 64'(imem_req_valid), 64'(0));
    ird_r = 1; step();
    ird_r = 0; step();
    chk("t2_third_req", 64'(acc_log.size()), 64'(3));
    if (acc_log.size() == 3) chk("t2_third_addr", acc_log[2], 64'h8);
    step(); step();

    // 3: B with imm26 = -2 from 0x40, nothing outstanding
    br_r = 1; unc_r = 1; binst_r = {OP_B, 26'h3FF_FFFE}; bpc_r = 64'h40;
    step();
    br_r = 0; step();
    chk("t3_flushed", 64'(inst_valid), 64'(0));
    chk("t3_req_valid", 64'(imem_req_valid), 64'(1));
    chk("t3_target", imem_addr, 64'h38);

    // 4: CBZ imm19 = +3 from 0x100 with a request in flight
    ird_r = 1; lat = 3;
    wait_acc("t4_acc_timeout", 20);
    pop_log.delete(); acc_log.delete();
    br_r = 1; unc_r = 0; binst_r = {OP_CBZ, 19'd3, 5'd0}; bpc_r = 64'h100;
    step();
    br_r = 0; lat = 1;
    wait_acc("t4_redir_timeout", 20);
    if (acc_log.size() > 0) chk("t4_target", acc_log[0], 64'h10C);
    repeat (6) step();
    chk("t4_npop", 64'(pop_log.size() > 0), 64'(1));
    if (pop_log.size() > 0) chk("t4_first_pc", pop_log[0], 64'h10C);

    // 5: PC wrap at the top of the address space
    br_r = 1; unc_r = 1; binst_r = {OP_B, 26'h0}; bpc_r = 64'hFFFF_FFFF_FFFF_FFFC;
    step();
    br_r = 0; acc_log.delete();
    wait_acc("t5_acc0_timeout", 20);
    wait_acc("t5_acc1_timeout", 20);
    if (acc_log.size() >= 2) begin
      chk("t5_top", acc_log[0], 64'hFFFF_FFFF_FFFF_FFFC);
      chk("t5_wrap", acc_log[1], 64'h0);
    end

    // 6: reset while waiting; response lands during reset (k=1) or in IDLE (k=2)
    for (int l = 1; l <= 2; l++) begin
      lat = l; ird_r = 0;
      wait_acc("t6_acc_timeout", 20);
      rst_r = 0; step();
      rst_r = 1; step();
      chk("t6_idle_inst_valid", 64'(inst_valid), 64'(0));
      acc_log.delete();
      wait_acc("t6_first_timeout", 20);
      if (acc_log.size() > 0) chk("t6_first_addr", acc_log[0], RPC);
      ird_r = 1; repeat (4) step();
    end

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rst_r = ($urandom_range(0, 199) != 0);
      rdy_r = ($urandom_range(0, 9) < 7);
      ird_r = ($urandom_range(0, 9) < 6);
      lat   = $urandom_range(1, 3);
      br_r  = ($urandom_range(0, 99) < 4);
      unc_r = $urandom_range(0, 1);
      if (unc_r) binst_r = {OP_B, 26'($urandom)};
      else binst_r = {($urandom_range(0, 1) != 0) ? OP_CBZ : OP_BCOND, 24'($urandom)};
      bpc_r = {$urandom, $urandom} & ~64'h3;
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
